// File: rtl/led_pwm_gen_pkg.sv
// Shared constants, FSM state type and duty clamp for the LED PWM generator.
package led_pwm_pkg;

   localparam int STEPS  = 10;
   localparam int DUTY_W = 4;

   localparam logic [DUTY_W-1:0] MAX_DUTY  = DUTY_W'(STEPS);
   localparam logic [DUTY_W-1:0] LAST_SLOT = DUTY_W'(STEPS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
      if (d > MAX_DUTY) begin
         return MAX_DUTY;
      end else begin
         return d;
      end
   endfunction

endpackage

// File: rtl/led_pwm_gen_if.sv
// Control/status bundle between the fade-ramp side and the PWM generator.
interface led_pwm_if;
   import led_pwm_pkg::*;

   logic              en;
   logic [DUTY_W-1:0] duty_in;
   logic              pwm_out;
   logic              period_strobe;
   logic [DUTY_W-1:0] duty_q;
   logic              busy;

   modport master (
      output en, duty_in,
      input  pwm_out, period_strobe, duty_q, busy
   );

   modport slave (
      input  en, duty_in,
      output pwm_out, period_strobe, duty_q, busy
   );
endinterface

// File: rtl/led_pwm_gen_slot_tick.sv
// Slot prescaler: counts clocks within one PWM slot and flags the wrap.
module slot_tick
   import led_pwm_pkg::*;
#(
   parameter int SLOT_CYCLES = 100,
   parameter int PRE_W       = 9
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic tick
);

   localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(SLOT_CYCLES - 1);

   logic [PRE_W-1:0] pre_r;

   assign tick = run && (pre_r == LAST_PRE);

   // Prescaler: held at zero while cleared, wraps at the end of each slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_r <= {PRE_W{1'b0}};
      end else if (clr) begin
         pre_r <= {PRE_W{1'b0}};
      end else if (run) begin
         pre_r <= tick ? {PRE_W{1'b0}} : pre_r + PRE_W'(1);
      end else begin
         pre_r <= pre_r;
      end
   end

endmodule

// File: rtl/led_pwm_gen.sv
// PWM generator: slot counter, run/drain FSM and registered PWM outputs.
// The duty level is sampled only at period boundaries so pulses are never cut short.
module led_pwm_gen
   import led_pwm_pkg::*;
#(
   parameter int SLOT_CYCLES = 100,
   parameter int PRE_W       = 9
) (
   input  logic     clk,
   input  logic     rst,
   led_pwm_if.slave bus
);

   state_e            state_r;
   state_e            state_nxt_s;
   logic [DUTY_W-1:0] slot_r;
   logic [DUTY_W-1:0] slot_nxt_s;
   logic [DUTY_W-1:0] duty_r;
   logic [DUTY_W-1:0] duty_nxt_s;
   logic              strobe_nxt_s;
   logic              pwm_nxt_s;
   logic              pwm_r;
   logic              strobe_r;
   logic              busy_r;
   logic              tick_s;
   logic              boundary_s;
   logic              active_s;

   assign active_s   = (state_r != IDLE);
   assign boundary_s = tick_s && (slot_r == LAST_SLOT);

   slot_tick #(
      .SLOT_CYCLES (SLOT_CYCLES),
      .PRE_W       (PRE_W)
   ) u_slot_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (!active_s),
      .run  (active_s),
      .tick (tick_s)
   );

   // Next-state decode; DRAIN differs from RUN only in that it has seen en low.
   always_comb begin
      state_nxt_s  = state_r;
      slot_nxt_s   = slot_r;
      duty_nxt_s   = duty_r;
      strobe_nxt_s = 1'b0;
      case (state_r)
         IDLE: begin
            slot_nxt_s = 4'd0;
            if (bus.en) begin
               state_nxt_s  = RUN;
               duty_nxt_s   = clamp_duty(bus.duty_in);
               strobe_nxt_s = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN, DRAIN: begin
            if (tick_s) begin
               slot_nxt_s = (slot_r == LAST_SLOT) ? 4'd0 : slot_r + 4'd1;
            end else begin
               slot_nxt_s = slot_r;
            end
            if (boundary_s) begin
               if (bus.en) begin
                  state_nxt_s  = RUN;
                  duty_nxt_s   = clamp_duty(bus.duty_in);
                  strobe_nxt_s = 1'b1;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else if (bus.en) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            slot_nxt_s  = 4'd0;
         end
      endcase
      pwm_nxt_s = (state_nxt_s != IDLE) && (slot_nxt_s < duty_nxt_s);
   end

   // FSM, slot counter, duty latch and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= IDLE;
         slot_r   <= 4'd0;
         duty_r   <= 4'd0;
         pwm_r    <= 1'b0;
         strobe_r <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         slot_r   <= slot_nxt_s;
         duty_r   <= duty_nxt_s;
         pwm_r    <= pwm_nxt_s;
         strobe_r <= strobe_nxt_s;
         busy_r   <= (state_nxt_s != IDLE);
      end
   end

   assign bus.pwm_out       = pwm_r;
   assign bus.period_strobe = strobe_r;
   assign bus.duty_q        = duty_r;
   assign bus.busy          = busy_r;

endmodule

// File: tb/tb_led_pwm_gen.sv
// Self-checking bench for led_pwm_gen: period-level reference model checked every
// cycle, plus hand-computed high-time/strobe counts per period.
module tb_led_pwm_gen;
   localparam int SLOT = 4;
   localparam int P    = 10 * SLOT;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   led_pwm_if bus();

   led_pwm_gen #(.SLOT_CYCLES(SLOT), .PRE_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: whether a period is in progress, position in it, level in force.
   bit m_active = 1'b0;
   bit m_strobe = 1'b0;
   int m_phase  = 0;
   int m_duty   = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active <= 1'b0;
         m_strobe <= 1'b0;
         m_phase  <= 0;
         m_duty   <= 0;
      end else if (!m_active || m_phase == P - 1) begin
         if (bus.en) begin
            m_active <= 1'b1;
            m_phase  <= 0;
            m_duty   <= (int'(bus.duty_in) > 10) ? 10 : int'(bus.duty_in);
            m_strobe <= 1'b1;
         end else begin
            m_active <= 1'b0;
            m_phase  <= 0;
            m_strobe <= 1'b0;
         end
      end else begin
         m_phase  <= m_phase + 1;
         m_strobe <= 1'b0;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         check("pwm_out", int'(bus.pwm_out), int'(m_active && (m_phase < m_duty * SLOT)));
         check("period_strobe", int'(bus.period_strobe), int'(m_strobe));
         check("busy", int'(bus.busy), int'(m_active));
         if (m_active) check("duty_q", int'(bus.duty_q), m_duty);
      end
   end

   task automatic count_window(input int n, output int hi, output int st);
      hi = 0;
      st = 0;
      repeat (n) begin
         @(negedge clk);
         hi += int'(bus.pwm_out);
         st += int'(bus.period_strobe);
      end
   endtask

   int hi, st, hi2, st2;

   initial begin
      bus.en      = 1'b0;
      bus.duty_in = 4'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_pwm", int'(bus.pwm_out), 0);
      check("reset_strobe", int'(bus.period_strobe), 0);
      check("reset_duty_q", int'(bus.duty_q), 0);
      check("reset_busy", int'(bus.busy), 0);

      // duty 3: 12 high / 28 low, one strobe per period
      bus.duty_in = 4'd3;
      bus.en      = 1'b1;
      count_window(P, hi, st);
      check("d3_high_p1", hi, 12);
      check("d3_strobe_p1", st, 1);
      check("d3_duty_q", int'(bus.duty_q), 3);
      count_window(P, hi, st);
      check("d3_high_p2", hi, 12);
      check("d3_strobe_p2", st, 1);

      // duty 0: constant low, strobe still present
      bus.duty_in = 4'd0;
      count_window(P, hi, st);
      check("d0_high", hi, 0);
      check("d0_strobe", st, 1);

      // duty 10: constant high for three periods
      bus.duty_in = 4'd10;
      count_window(3 * P, hi, st);
      check("d10_high_3p", hi, 3 * P);
      check("d10_strobes", st, 3);

      // duty 15 clamps to 10
      bus.duty_in = 4'd15;
      count_window(P, hi, st);
      check("d15_high", hi, P);
      check("d15_duty_q", int'(bus.duty_q), 10);

      // ramp 4 -> 7 mid-period takes effect only at the next boundary
      bus.duty_in = 4'd4;
      count_window(P, hi, st);
      check("d4_high", hi, 16);
      count_window(10, hi, st);
      bus.duty_in = 4'd7;
      count_window(P - 10, hi2, st2);
      check("ramp_cur_high", hi + hi2, 16);
      check("ramp_cur_duty_q", int'(bus.duty_q), 4);
      count_window(P, hi, st);
      check("ramp_next_high", hi, 28);
      check("ramp_next_duty_q", int'(bus.duty_q), 7);

      // en drops at clock 5 of a d=5 period: period completes, then idle
      bus.duty_in = 4'd5;
      count_window(5, hi, st);
      bus.en = 1'b0;
      count_window(P - 5, hi2, st2);
      check("drain_high", hi + hi2, 20);
      check("drain_strobe", st + st2, 1);
      @(negedge clk);
      check("stop_busy", int'(bus.busy), 0);
      check("stop_pwm", int'(bus.pwm_out), 0);
      repeat (3) @(negedge clk);
      check("idle_busy", int'(bus.busy), 0);

      // en re-raised at clock 30 of a draining period: no restart, strobe at clock 40
      bus.en = 1'b1;
      count_window(5, hi, st);
      bus.en = 1'b0;
      count_window(25, hi2, st2);
      hi += hi2; st += st2;
      bus.en = 1'b1;
      count_window(P - 30, hi2, st2);
      check("resume_high", hi + hi2, 20);
      check("resume_strobe", st + st2, 1);
      count_window(1, hi, st);
      check("resume_strobe_at_40", st, 1);
      check("resume_busy", int'(bus.busy), 1);

      // reset at clock 7 of a d=10 period
      bus.duty_in = 4'd10;
      count_window(P - 1, hi, st);
      count_window(7, hi, st);
      check("pre_rst_high", hi, 7);
      #2;
      rst    = 1'b1;
      bus.en = 1'b0;
      #1;
      check("async_rst_pwm", int'(bus.pwm_out), 0);
      check("async_rst_busy", int'(bus.busy), 0);
      check("async_rst_duty_q", int'(bus.duty_q), 0);
      check("async_rst_strobe", int'(bus.period_strobe), 0);
      @(negedge clk);
      rst = 1'b0;
      count_window(5, hi, st);
      check("post_rst_idle_high", hi, 0);
      check("post_rst_idle_busy", int'(bus.busy), 0);
      bus.en = 1'b1;
      count_window(P, hi, st);
      check("post_rst_d10_high", hi, P);
      check("post_rst_strobe", st, 1);

      bus.en = 1'b0;
      repeat (P + 2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
